// File: rtl/lr_stream_packer.sv
// Packs camera L/R pixel pairs into 32-bit LR AXI-Stream words, two pairs per word, with frame/line markers.
// A small output FIFO absorbs back-pressure, and sticky flags report framing errors and dropped words.
module lr_stream_packer #(
    parameter int C_AXIS_LR_TDATA_WIDTH = 32,
    parameter int LINE_PAIRS            = 640,
    parameter int FIFO_DEPTH            = 16
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             cam_valid,
    input  logic [15:0]                      cam_data,
    input  logic                             cam_sof,
    input  logic                             cam_eol,
    input  logic                             err_clr,
    output logic                             m_axis_lr_tvalid,
    output logic [C_AXIS_LR_TDATA_WIDTH-1:0] m_axis_lr_tdata,
    input  logic                             m_axis_lr_tready,
    output logic                             m_axis_lr_tlast,
    output logic                             m_axis_lr_tuser,
    output logic                             err_line,
    output logic                             err_sof,
    output logic                             err_ovf
);

    localparam int CW   = $clog2(LINE_PAIRS + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CW-1:0]   LP_CNT   = CW'(LINE_PAIRS);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        LOW      = 2'd1,
        HIGH     = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] pair_cnt;
    logic [CW-1:0] cnt_inc;
    logic          at_line_end;
    logic          sof_pend;
    logic [15:0]   low_half;

    // Word completed by the packer last cycle; it enters the FIFO on this edge.
    logic          push_vld;
    logic [31:0]   push_data;
    logic          push_last;
    logic          push_user;

    logic [33:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_next;
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] avail;
    logic            pop;
    logic            full;
    logic            wr;
    logic            drop;

    assign cnt_inc     = pair_cnt + CW'(1);
    assign at_line_end = (cnt_inc == LP_CNT);

    // Handshake: a word transfers on every rising edge where tvalid && tready; once raised,
    // tvalid and the word stay put until that transfer (only reset can withdraw them).
    assign pop     = m_axis_lr_tvalid && m_axis_lr_tready;
    assign full    = (count == FULL_CNT);
    assign wr      = push_vld && (!full || pop);
    assign drop    = push_vld && full && !pop;
    assign avail   = count - CNTW'(pop);
    assign rd_next = rd_ptr + AW'(pop);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= WAIT_SOF;
            pair_cnt  <= '0;
            sof_pend  <= 1'b0;
            low_half  <= '0;
            push_vld  <= 1'b0;
            push_data <= '0;
            push_last <= 1'b0;
            push_user <= 1'b0;
            err_line  <= 1'b0;
            err_sof   <= 1'b0;
        end else begin
            push_vld <= 1'b0;
            if (err_clr) begin
                err_line <= 1'b0;
                err_sof  <= 1'b0;
            end
            if (cam_valid) begin
                if (cam_sof) begin
                    // A sof pair always opens a fresh frame as the low half, whatever came before.
                    if (state == HIGH || (state == LOW && pair_cnt != '0)) begin
                        err_sof <= 1'b1;
                    end
                    if (cam_eol) begin
                        push_vld  <= 1'b1;
                        push_data <= {16'h0000, cam_data};
                        push_last <= 1'b1;
                        push_user <= 1'b1;
                        err_line  <= 1'b1;
                        pair_cnt  <= '0;
                        sof_pend  <= 1'b0;
                        state     <= LOW;
                    end else begin
                        low_half <= cam_data;
                        pair_cnt <= CW'(1);
                        sof_pend <= 1'b1;
                        state    <= HIGH;
                    end
                end else begin
                    case (state)
                        WAIT_SOF: begin
                            state <= WAIT_SOF;
                        end
                        LOW: begin
                            if (cam_eol) begin
                                push_vld  <= 1'b1;
                                push_data <= {16'h0000, cam_data};
                                push_last <= 1'b1;
                                push_user <= sof_pend;
                                err_line  <= 1'b1;
                                pair_cnt  <= '0;
                                sof_pend  <= 1'b0;
                            end else begin
                                low_half <= cam_data;
                                pair_cnt <= cnt_inc;
                                state    <= HIGH;
                            end
                        end
                        HIGH: begin
                            push_vld  <= 1'b1;
                            push_data <= {cam_data, low_half};
                            push_last <= at_line_end || cam_eol;
                            push_user <= sof_pend;
                            sof_pend  <= 1'b0;
                            if (cam_eol != at_line_end) begin
                                err_line <= 1'b1;
                            end
                            pair_cnt <= (at_line_end || cam_eol) ? '0 : cnt_inc;
                            state    <= LOW;
                        end
                        default: begin
                            state <= WAIT_SOF;
                        end
                    endcase
                end
            end
            // A dropped frame-start word hands its tuser on to the next word.
            if (drop && push_user) begin
                sof_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (wr) begin
            mem[wr_ptr] <= {push_user, push_last, push_data};
        end
    end

    // Output registers hold the FIFO head; a word written this edge is visible one edge later.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            m_axis_lr_tvalid <= 1'b0;
            m_axis_lr_tdata  <= '0;
            m_axis_lr_tlast  <= 1'b0;
            m_axis_lr_tuser  <= 1'b0;
            err_ovf          <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count + CNTW'(wr) - CNTW'(pop);
            if (!m_axis_lr_tvalid || pop) begin
                m_axis_lr_tvalid <= (avail != '0);
                if (avail != '0) begin
                    {m_axis_lr_tuser, m_axis_lr_tlast, m_axis_lr_tdata} <= mem[rd_next];
                end
            end
            if (err_clr) begin
                err_ovf <= 1'b0;
            end
            if (drop) begin
                err_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lr_stream_packer.sv
// Bench for lr_stream_packer: directed framing/back-pressure/reset scenarios plus randomized traffic,
// all compared every cycle against a queue-based model of the packer and its output FIFO.
module tb_lr_stream_packer;

    localparam int LP    = 4;
    localparam int DEPTH = 4;
    localparam int W     = 34;

    logic        aclk      = 1'b0;
    logic        aresetn   = 1'b0;
    logic        cam_valid = 1'b0;
    logic [15:0] cam_data  = '0;
    logic        cam_sof   = 1'b0;
    logic        cam_eol   = 1'b0;
    logic        err_clr   = 1'b0;
    logic        tready    = 1'b0;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic        tuser;
    logic        err_line;
    logic        err_sof;
    logic        err_ovf;

    int checks = 0;
    int errors = 0;

    lr_stream_packer #(
        .C_AXIS_LR_TDATA_WIDTH(32),
        .LINE_PAIRS(LP),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .cam_valid(cam_valid),
        .cam_data(cam_data),
        .cam_sof(cam_sof),
        .cam_eol(cam_eol),
        .err_clr(err_clr),
        .m_axis_lr_tvalid(tvalid),
        .m_axis_lr_tdata(tdata),
        .m_axis_lr_tready(tready),
        .m_axis_lr_tlast(tlast),
        .m_axis_lr_tuser(tuser),
        .err_line(err_line),
        .err_sof(err_sof),
        .err_ovf(err_ovf)
    );

    // Clock / reset
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after a rising edge and are sampled at the next one.
    task automatic drive(input logic v, input logic [15:0] d, input logic s, input logic e, input logic c);
        @(posedge aclk);
        #1;
        cam_valid = v;
        cam_data  = d;
        cam_sof   = s;
        cam_eol   = e;
        err_clr   = c;
    endtask

    task automatic pair(input logic [15:0] d, input logic s, input logic e);
        drive(1'b1, d, s, e, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    // Behavioural model: exp_q is the expected FIFO content (head first), m_head/m_tvalid the output stage.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] out_log[$];
    logic         m_tvalid;
    logic [W-1:0] m_head;
    logic         m_pend_vld;
    logic [W-1:0] m_pend;
    bit           m_in_frame;
    int           m_pos;
    logic [15:0]  m_low;
    logic         m_sof_pend;
    logic         m_err_line;
    logic         m_err_sof;
    logic         m_err_ovf;

    task automatic model_reset();
        exp_q.delete();
        m_tvalid   = 1'b0;
        m_head     = '0;
        m_pend_vld = 1'b0;
        m_pend     = '0;
        m_in_frame = 1'b0;
        m_pos      = 0;
        m_low      = '0;
        m_sof_pend = 1'b0;
        m_err_line = 1'b0;
        m_err_sof  = 1'b0;
        m_err_ovf  = 1'b0;
    endtask

    task automatic model_step();
        int size_before;
        bit pop, rearm, set_ovf, set_line, set_sof, last;
        pop         = m_tvalid && tready;
        size_before = exp_q.size();
        rearm       = 1'b0;
        set_ovf     = 1'b0;
        set_line    = 1'b0;
        set_sof     = 1'b0;
        if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (m_pend_vld) begin
            if (size_before == DEPTH && !pop) begin
                set_ovf = 1'b1;
                rearm   = m_pend[33];
            end else begin
                exp_q.push_back(m_pend);
            end
        end
        if (!m_tvalid || pop) m_tvalid = (size_before - int'(pop)) > 0;
        if (m_tvalid) m_head = exp_q[0];
        m_pend_vld = 1'b0;
        if (cam_valid) begin
            if (cam_sof) begin
                if (m_in_frame && m_pos != 0) set_sof = 1'b1;
                m_in_frame = 1'b1;
                m_pos      = 0;
                m_sof_pend = 1'b1;
            end
            if (m_in_frame) begin
                m_pos++;
                if (m_pos % 2 == 1) begin
                    if (cam_eol) begin
                        m_pend_vld = 1'b1;
                        m_pend     = {m_sof_pend, 1'b1, 16'h0000, cam_data};
                        set_line   = 1'b1;
                        m_pos      = 0;
                        m_sof_pend = 1'b0;
                    end else begin
                        m_low = cam_data;
                    end
                end else begin
                    last = (m_pos == LP) || cam_eol;
                    if ((m_pos == LP) != cam_eol) set_line = 1'b1;
                    m_pend_vld = 1'b1;
                    m_pend     = {m_sof_pend, last, cam_data, m_low};
                    m_sof_pend = 1'b0;
                    if (last) m_pos = 0;
                end
            end
        end
        if (rearm) m_sof_pend = 1'b1;
        if (err_clr) begin
            m_err_line = 1'b0;
            m_err_sof  = 1'b0;
            m_err_ovf  = 1'b0;
        end
        if (set_line) m_err_line = 1'b1;
        if (set_sof) m_err_sof = 1'b1;
        if (set_ovf) m_err_ovf = 1'b1;
    endtask

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) model_reset();
        else model_step();
    end

    // Scoreboard compare, away from the active edge; also logs every accepted word.
    always @(negedge aclk) begin
        check("tvalid", tvalid, m_tvalid);
        if (m_tvalid) check("word", {tuser, tlast, tdata}, m_head);
        check("err_line", err_line, m_err_line);
        check("err_sof", err_sof, m_err_sof);
        check("err_ovf", err_ovf, m_err_ovf);
        if (aresetn && tvalid && tready) out_log.push_back({tuser, tlast, tdata});
    end

    task automatic check_word(input string name, input int idx, input logic [W-1:0] exp);
        if (idx < out_log.size()) check(name, out_log[idx], exp);
        else check({name, "_count"}, out_log.size(), idx + 1);
    endtask

    task automatic fresh_test();
        tready = 1'b1;
        idle(10);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        idle(1);
        out_log.delete();
    endtask

    initial begin
        idle(3);
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tdata", tdata, 32'h0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_tuser", tuser, 1'b0);
        check("rst_err_line", err_line, 1'b0);
        check("rst_err_sof", err_sof, 1'b0);
        check("rst_err_ovf", err_ovf, 1'b0);
        aresetn = 1'b1;

        // 1) one clean line with tready high
        fresh_test();
        pair(16'h0201, 1'b1, 1'b0);
        pair(16'h0403, 1'b0, 1'b0);
        pair(16'h0605, 1'b0, 1'b0);
        pair(16'h0807, 1'b0, 1'b1);
        idle(6);
        check_word("t1_w0", 0, {1'b1, 1'b0, 32'h04030201});
        check_word("t1_w1", 1, {1'b0, 1'b1, 32'h08070605});
        check("t1_err_line", err_line, 1'b0);
        check("t1_err_sof", err_sof, 1'b0);
        check("t1_err_ovf", err_ovf, 1'b0);

        // 2) same line under 20 cycles of back-pressure
        fresh_test();
        tready = 1'b0;
        pair(16'h0201, 1'b1, 1'b0);
        pair(16'h0403, 1'b0, 1'b0);
        pair(16'h0605, 1'b0, 1'b0);
        pair(16'h0807, 1'b0, 1'b1);
        idle(4);
        for (int i = 0; i < 16; i++) begin
            idle(1);
            check("t2_hold_valid", tvalid, 1'b1);
            check("t2_hold_data", tdata, 32'h04030201);
        end
        tready = 1'b1;
        idle(8);
        check_word("t2_w0", 0, {1'b1, 1'b0, 32'h04030201});
        check_word("t2_w1", 1, {1'b0, 1'b1, 32'h08070605});
        check("t2_count", out_log.size(), 2);

        // 3) early eol on the 3rd pair, then a normal line
        fresh_test();
        pair(16'h0201, 1'b1, 1'b0);
        pair(16'h0403, 1'b0, 1'b0);
        pair(16'h0605, 1'b0, 1'b1);
        pair(16'h0A09, 1'b0, 1'b0);
        pair(16'h0C0B, 1'b0, 1'b0);
        pair(16'h0E0D, 1'b0, 1'b0);
        pair(16'h100F, 1'b0, 1'b1);
        idle(6);
        check_word("t3_w0", 0, {1'b1, 1'b0, 32'h04030201});
        check_word("t3_w1", 1, {1'b0, 1'b1, 32'h00000605});
        check_word("t3_w2", 2, {1'b0, 1'b0, 32'h0C0B0A09});
        check_word("t3_w3", 3, {1'b0, 1'b1, 32'h100F0E0D});
        check("t3_err_line", err_line, 1'b1);

        // 4) sof on the 2nd pair of a line
        fresh_test();
        pair(16'h0201, 1'b1, 1'b0);
        pair(16'h0403, 1'b1, 1'b0);
        pair(16'h0605, 1'b0, 1'b0);
        pair(16'h0807, 1'b0, 1'b0);
        pair(16'h0A09, 1'b0, 1'b1);
        idle(6);
        check_word("t4_w0", 0, {1'b1, 1'b0, 32'h06050403});
        check_word("t4_w1", 1, {1'b0, 1'b1, 32'h0A090807});
        check("t4_err_sof", err_sof, 1'b1);
        check("t4_err_line", err_line, 1'b0);

        // 5) overflow with depth 4, then err_clr and set-dominance
        fresh_test();
        tready = 1'b0;
        for (int k = 0; k < 12; k++) pair({8'(2 * k + 2), 8'(2 * k + 1)}, k == 0, k % 4 == 3);
        idle(4);
        check("t5_err_ovf", err_ovf, 1'b1);
        tready = 1'b1;
        idle(12);
        check("t5_retained", out_log.size(), 4);
        check_word("t5_w0", 0, {1'b1, 1'b0, 32'h04030201});
        check_word("t5_w3", 3, {1'b0, 1'b1, 32'h100F0E0D});
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("t5_clr", err_ovf, 1'b0);
        out_log.delete();
        tready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, {8'(2 * k + 2), 8'(2 * k + 1)}, k == 0, k % 4 == 3, k == 11);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        @(negedge aclk);
        check("t5_cleared_before_drop", err_ovf, 1'b0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge aclk);
        check("t5_set_dominant", err_ovf, 1'b1);

        // 6) reset mid-line, pre-sof pairs discarded
        fresh_test();
        tready = 1'b0;
        pair(16'h1111, 1'b1, 1'b0);
        pair(16'h2222, 1'b0, 1'b0);
        pair(16'h3333, 1'b0, 1'b0);
        idle(3);
        check("t6_pre_valid", tvalid, 1'b1);
        aresetn = 1'b0;
        #1;
        check("t6_rst_tvalid", tvalid, 1'b0);
        check("t6_rst_tdata", tdata, 32'h0);
        check("t6_rst_tlast", tlast, 1'b0);
        check("t6_rst_tuser", tuser, 1'b0);
        check("t6_rst_err_ovf", err_ovf, 1'b0);
        idle(2);
        aresetn = 1'b1;
        tready  = 1'b1;
        out_log.delete();
        pair(16'h5555, 1'b0, 1'b0);
        pair(16'h6666, 1'b0, 1'b0);
        pair(16'h7777, 1'b0, 1'b0);
        pair(16'h8888, 1'b0, 1'b1);
        idle(5);
        check("t6_no_output", out_log.size(), 0);
        pair(16'h0201, 1'b1, 1'b0);
        pair(16'h0403, 1'b0, 1'b0);
        idle(5);
        check_word("t6_w0", 0, {1'b1, 1'b0, 32'h04030201});

        // Randomized traffic with back-pressure, framing faults and one reset
        fresh_test();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 75, 16'($urandom), $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3);
            tready = $urandom_range(0, 99) < 70;
            if (i == 1500) aresetn = 1'b0;
            if (i == 1503) aresetn = 1'b1;
        end
        tready = 1'b1;
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
